peb_wb_arbiter: RTL

//  Two-master Wishbone arbiter in front of the PEB Wishbone slave port (FDC/card register space).

---
 rtl/peb_wb_pkg.sv | 12 +
 rtl/peb_wb_rr_pick.sv | 18 +
 rtl/peb_wb_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/peb_wb_pkg.sv
// Shared widths, master indices and FSM encoding for the PEB Wishbone arbiter.
package peb_wb_pkg;
  localparam int PEB_WB_AW = 23;
  localparam int PEB_WB_DW = 8;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic {ST_IDLE, ST_OWN} state_t;

  localparam logic [PEB_WB_DW-1:0] PEB_WB_ERR_DAT = 8'hff;
endpackage

// File: rtl/peb_wb_rr_pick.sv
// Two-way round-robin picker: on contention the master that did not own the bus last wins.
module peb_wb_rr_pick
  import peb_wb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_last == M1) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/peb_wb_arbiter.sv
// Two-master Wishbone arbiter for the PEB slave port: round-robin grant locked
// for the owner's cyc tenure, with a per-strobe timeout that returns an error ack.
module peb_wb_arbiter
  import peb_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [PEB_WB_AW-1:0] m0_adr_i,
  input  logic [PEB_WB_DW-1:0] m0_dat_i,
  output logic [PEB_WB_DW-1:0] m0_dat_o,
  input  logic                 m0_we_i,
  input  logic                 m0_sel_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_cyc_i,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  input  logic [PEB_WB_AW-1:0] m1_adr_i,
  input  logic [PEB_WB_DW-1:0] m1_dat_i,
  output logic [PEB_WB_DW-1:0] m1_dat_o,
  input  logic                 m1_we_i,
  input  logic                 m1_sel_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_cyc_i,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic [PEB_WB_AW-1:0] s_adr_o,
  output logic [PEB_WB_DW-1:0] s_dat_o,
  input  logic [PEB_WB_DW-1:0] s_dat_i,
  output logic                 s_we_o,
  output logic                 s_sel_o,
  output logic                 s_stb_o,
  output logic                 s_cyc_o,
  input  logic                 s_ack_i,
  output logic [1:0]           gnt_o
);
  localparam logic [9:0] TMR_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_rr_last, w_rr_last_nxt;
  logic [9:0] r_timer;

  logic [1:0] w_req, w_pick;
  logic       w_own_cyc, w_own_stb, w_granted, w_raw_stb, w_timeout, w_ack;
  logic [PEB_WB_DW-1:0] w_rdat;

  assign w_req     = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign w_own_cyc = (r_owner == M1) ? m1_cyc_i : m0_cyc_i;
  assign w_own_stb = (r_owner == M1) ? m1_stb_i : m0_stb_i;
  assign w_granted = (r_state == ST_OWN);

  peb_wb_rr_pick u_pick (
    .i_req  (w_req),
    .i_last (r_rr_last),
    .o_gnt  (w_pick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= M0;
      r_rr_last <= M1;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_last <= w_rr_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_rr_last_nxt = r_rr_last;
    case (r_state)
      ST_IDLE: if (|w_pick) begin
        w_state_nxt = ST_OWN;
        w_owner_nxt = w_pick[1];
      end
      ST_OWN: if (!w_own_cyc) begin
        w_state_nxt   = ST_IDLE;
        w_rr_last_nxt = r_owner;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Timeout masks the strobe for one cycle; a coincident ack takes priority.
  always_comb begin
    s_cyc_o   = w_granted & w_own_cyc;
    w_raw_stb = s_cyc_o & w_own_stb;
    w_timeout = w_raw_stb & (r_timer == TMR_LAST) & ~s_ack_i;
    s_stb_o   = w_raw_stb & ~w_timeout;
    w_ack     = s_ack_i & s_stb_o;
    w_rdat    = w_timeout ? PEB_WB_ERR_DAT : s_dat_i;

    s_adr_o   = (r_owner == M1) ? m1_adr_i : m0_adr_i;
    s_dat_o   = (r_owner == M1) ? m1_dat_i : m0_dat_i;
    s_we_o    = (r_owner == M1) ? m1_we_i  : m0_we_i;
    s_sel_o   = (r_owner == M1) ? m1_sel_i : m0_sel_i;

    m0_ack_o  = w_ack     & (r_owner == M0);
    m0_err_o  = w_timeout & (r_owner == M0);
    m0_dat_o  = (w_granted && r_owner == M0) ? w_rdat : '0;
    m1_ack_o  = w_ack     & (r_owner == M1);
    m1_err_o  = w_timeout & (r_owner == M1);
    m1_dat_o  = (w_granted && r_owner == M1) ? w_rdat : '0;
    gnt_o     = {w_granted & r_owner, w_granted & ~r_owner};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_timer <= '0;
    else if (!s_stb_o || s_ack_i) r_timer <= '0;
    else                         r_timer <= r_timer + 10'd1;
  end
endmodule
